// File: rtl/rx_fifo_pkg.sv
// Shared types and defaults for the receive frame FIFO.
// A buffer entry carries one received byte plus its end-of-frame marker.
package rx_fifo_pkg;

    localparam int DEPTH_DEF = 2048;
    localparam int CNT_W_DEF = 16;

    typedef struct packed {
        logic       last;
        logic [7:0] data;
    } rx_entry_t;

endpackage

// File: rtl/rx_frame_ram.sv
// Simple dual-port frame RAM: synchronous write, registered synchronous read.
// The read register doubles as the FIFO output register, so it only loads on rd_en.
module rx_frame_ram
    import rx_fifo_pkg::*;
#(
    parameter int ADDR_W = 11
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  rx_entry_t         wr_entry,
    input  logic              rd_en,
    input  logic [ADDR_W-1:0] rd_addr,
    output rx_entry_t         rd_entry
);

    rx_entry_t mem [0:(1<<ADDR_W)-1];

    always_ff @(posedge clk) begin
        if (wr_en)
            mem[wr_addr] <= wr_entry;
    end

    // Only the read register is reset; the array stays uninitialised.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            rd_entry <= '0;
        else if (rd_en)
            rd_entry <= mem[rd_addr];
    end

endmodule

// File: rtl/rx_frame_fifo.sv
// Receive frame FIFO: buffers MAC bytes and releases a frame to the reader only
// after its last byte arrives clean; bad or overflowing frames are rewound away.
module rx_frame_fifo
    import rx_fifo_pkg::*;
#(
    parameter int DEPTH  = DEPTH_DEF,
    parameter int ADDR_W = $clog2(DEPTH),
    parameter int CNT_W  = CNT_W_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [7:0]        in_data,
    input  logic              in_valid,
    input  logic              in_last,
    input  logic              in_error,
    output logic [7:0]        out_data,
    output logic              out_valid,
    output logic              out_last,
    input  logic              out_ready,
    output logic              frame_drop,
    output logic [CNT_W-1:0]  drop_count,
    output logic [ADDR_W:0]   frames_avail,
    output logic [ADDR_W:0]   fill_level
);

    localparam int PTR_W = ADDR_W + 1;
    typedef logic [PTR_W-1:0] ptr_t;
    localparam ptr_t PTR_ONE   = ptr_t'(1);
    localparam ptr_t PTR_DEPTH = ptr_t'(DEPTH);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    ptr_t      wr_ptr, rd_ptr, commit_ptr;
    logic      bad, dropping;
    logic      full, wr_en, rd_en, accept, commit;
    rx_entry_t wr_entry, rd_entry;

    assign full     = (wr_ptr - rd_ptr) == PTR_DEPTH;
    assign wr_en    = in_valid && !dropping && !full;
    assign commit   = wr_en && in_last && !bad && !in_error;
    assign rd_en    = (!out_valid || out_ready) && (rd_ptr != commit_ptr);
    assign accept   = out_valid && out_ready;
    assign wr_entry = '{last: in_last, data: in_data};

    assign out_data   = rd_entry.data;
    assign out_last   = rd_entry.last;
    assign fill_level = wr_ptr - rd_ptr;

    rx_frame_ram #(.ADDR_W(ADDR_W)) u_ram (
        .clk      (clk),
        .rst_n    (rst_n),
        .wr_en    (wr_en),
        .wr_addr  (wr_ptr[ADDR_W-1:0]),
        .wr_entry (wr_entry),
        .rd_en    (rd_en),
        .rd_addr  (rd_ptr[ADDR_W-1:0]),
        .rd_entry (rd_entry)
    );

    // Write side: only wr_ptr ever rewinds, and only as far as commit_ptr, so
    // committed bytes and the read side are untouched by a discard.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr     <= '0;
            commit_ptr <= '0;
            bad        <= 1'b0;
            dropping   <= 1'b0;
            frame_drop <= 1'b0;
            drop_count <= '0;
        end else begin
            frame_drop <= 1'b0;
            if (in_valid) begin
                if (dropping) begin
                    if (in_last)
                        dropping <= 1'b0;
                end else if (full) begin
                    wr_ptr     <= commit_ptr;
                    bad        <= 1'b0;
                    frame_drop <= 1'b1;
                    if (drop_count != '1)
                        drop_count <= drop_count + CNT_ONE;
                    if (!in_last)
                        dropping <= 1'b1;
                end else if (in_last) begin
                    bad <= 1'b0;
                    if (bad || in_error) begin
                        wr_ptr     <= commit_ptr;
                        frame_drop <= 1'b1;
                        if (drop_count != '1)
                            drop_count <= drop_count + CNT_ONE;
                    end else begin
                        wr_ptr     <= wr_ptr + PTR_ONE;
                        commit_ptr <= wr_ptr + PTR_ONE;
                    end
                end else begin
                    wr_ptr <= wr_ptr + PTR_ONE;
                    bad    <= bad | in_error;
                end
            end
        end
    end

    // Read side: one-entry output register held in the RAM read register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr    <= '0;
            out_valid <= 1'b0;
        end else if (rd_en) begin
            rd_ptr    <= rd_ptr + PTR_ONE;
            out_valid <= 1'b1;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            frames_avail <= '0;
        else begin
            case ({commit, accept && out_last})
                2'b10:   frames_avail <= frames_avail + PTR_ONE;
                2'b01:   frames_avail <= frames_avail - PTR_ONE;
                default: frames_avail <= frames_avail;
            endcase
        end
    end

endmodule

// File: tb/tb_rx_frame_fifo.sv
// Directed bench for rx_frame_fifo at DEPTH=64: good, errored, overflowing,
// back-pressured, wrapping and reset-interrupted frames.
module tb_rx_frame_fifo;

    localparam int DEPTH  = 64;
    localparam int ADDR_W = 6;
    localparam int CNT_W  = 16;

    logic              clk;
    logic              rst_n;
    logic [7:0]        in_data;
    logic              in_valid, in_last, in_error;
    logic [7:0]        out_data;
    logic              out_valid, out_last, out_ready;
    logic              frame_drop;
    logic [CNT_W-1:0]  drop_count;
    logic [ADDR_W:0]   frames_avail, fill_level;

    rx_frame_fifo #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .CNT_W(CNT_W)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .in_data      (in_data),
        .in_valid     (in_valid),
        .in_last      (in_last),
        .in_error     (in_error),
        .out_data     (out_data),
        .out_valid    (out_valid),
        .out_last     (out_last),
        .out_ready    (out_ready),
        .frame_drop   (frame_drop),
        .drop_count   (drop_count),
        .frames_avail (frames_avail),
        .fill_level   (fill_level)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int         n_checks = 0;
    int         n_fail   = 0;
    int         drop_pulses = 0;
    logic [8:0] rx[$];
    logic [8:0] exp_q[$];
    logic       stalled = 1'b0;
    logic [8:0] held;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_checks++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s got=%0h expected=%0h", tag, got, want);
        end
    endtask

    // Inputs only change at posedge+1, so negedge sees the values the next edge will use.
    always @(negedge clk) begin
        if (!rst_n) begin
            stalled = 1'b0;
        end else begin
            if (stalled)
                chk("stall_hold", 32'({out_valid, out_last, out_data}), 32'({1'b1, held}));
            if (out_valid && out_ready)
                rx.push_back({out_last, out_data});
            if (frame_drop)
                drop_pulses++;
            stalled = out_valid && !out_ready;
            held    = {out_last, out_data};
        end
    end

    task automatic send(input logic [7:0] d, input logic l, input logic e);
        in_data  = d;
        in_last  = l;
        in_error = e;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        in_last  = 1'b0;
        in_error = 1'b0;
    endtask

    task automatic send_frame(input int len, input logic [7:0] base, input int err_idx, input logic expect_out);
        for (int i = 0; i < len; i++) begin
            send(base + 8'(i), i == len - 1, i == err_idx);
            if (expect_out)
                exp_q.push_back({i == len - 1, base + 8'(i)});
        end
    endtask

    task automatic wait_rx(input int n, input int budget);
        int c;
        c = 0;
        while (rx.size() < n && c < budget) begin
            @(posedge clk); #1;
            c++;
        end
        chk("rx_count", 32'(rx.size()), 32'(n));
    endtask

    task automatic cmp_q(input string tag);
        chk(tag, 32'(rx.size()), 32'(exp_q.size()));
        for (int i = 0; i < rx.size() && i < exp_q.size(); i++)
            chk(tag, 32'(rx[i]), 32'(exp_q[i]));
        rx.delete();
        exp_q.delete();
    endtask

    task automatic idle(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    initial begin
        int first_drop;
        int pulses0;
        rst_n = 1'b0; in_data = '0; in_valid = 1'b0; in_last = 1'b0; in_error = 1'b0;
        out_ready = 1'b0;
        idle(3);
        chk("rst_out_valid", 32'(out_valid), 0);
        chk("rst_out_last", 32'(out_last), 0);
        chk("rst_out_data", 32'(out_data), 0);
        chk("rst_frame_drop", 32'(frame_drop), 0);
        chk("rst_drop_count", 32'(drop_count), 0);
        chk("rst_frames_avail", 32'(frames_avail), 0);
        chk("rst_fill_level", 32'(fill_level), 0);
        rst_n = 1'b1;
        idle(2);

        // Good 64-byte frame, reader always ready.
        out_ready = 1'b1;
        send_frame(64, 8'h00, -1, 1'b1);
        chk("good_ov_early", 32'(out_valid), 0);
        chk("good_avail_1", 32'(frames_avail), 1);
        idle(1);
        chk("good_ov_latency", 32'(out_valid), 1);
        chk("good_first_byte", 32'(out_data), 0);
        wait_rx(64, 200);
        idle(2);
        cmp_q("good_data");
        chk("good_avail_0", 32'(frames_avail), 0);
        chk("good_drop_count", 32'(drop_count), 0);

        // Errored frame then a clean one.
        pulses0 = drop_pulses;
        send_frame(20, 8'h40, 5, 1'b0);
        chk("err_drop_pulse_now", 32'(frame_drop), 1);
        send_frame(10, 8'h80, -1, 1'b1);
        wait_rx(10, 100);
        idle(3);
        cmp_q("err_data");
        chk("err_pulses", 32'(drop_pulses - pulses0), 1);
        chk("err_drop_count", 32'(drop_count), 1);
        chk("err_fill", 32'(fill_level), 0);

        // Overflow with a stalled reader. Byte 0 of frame 1 still moves into the
        // output register, so frame 2 overflows on its 26th byte (index 25).
        out_ready = 1'b0;
        pulses0 = drop_pulses;
        send_frame(40, 8'h10, -1, 1'b1);
        first_drop = -1;
        for (int i = 0; i < 40; i++) begin
            send(8'hC0 + 8'(i), i == 39, 1'b0);
            if (frame_drop && first_drop < 0)
                first_drop = i;
        end
        idle(2);
        chk("ovf_drop_index", 32'(first_drop), 25);
        chk("ovf_pulses", 32'(drop_pulses - pulses0), 1);
        chk("ovf_drop_count", 32'(drop_count), 2);
        chk("ovf_fill", 32'(fill_level), 39);
        chk("ovf_avail", 32'(frames_avail), 1);
        out_ready = 1'b1;
        wait_rx(40, 200);
        idle(5);
        cmp_q("ovf_data");
        chk("ovf_avail_0", 32'(frames_avail), 0);

        // Three back-to-back frames under random backpressure.
        fork
            begin
                send_frame(15, 8'h20, -1, 1'b1);
                send_frame(7, 8'h40, -1, 1'b1);
                send_frame(22, 8'h60, -1, 1'b1);
            end
            begin
                for (int c = 0; c < 2000 && rx.size() < 44; c++) begin
                    out_ready = 1'($urandom_range(0, 1));
                    @(posedge clk); #1;
                end
            end
        join
        out_ready = 1'b1;
        wait_rx(44, 100);
        idle(3);
        cmp_q("bp_data");
        chk("bp_avail", 32'(frames_avail), 0);

        // 100 frames of 37 bytes: pointers wrap many times.
        for (int f = 0; f < 100; f++)
            for (int i = 0; i < 37; i++) begin
                send(8'(f * 37 + i), i == 36, 1'b0);
                exp_q.push_back({i == 36, 8'(f * 37 + i)});
            end
        wait_rx(3700, 500);
        idle(3);
        cmp_q("wrap_data");
        chk("wrap_drop_count", 32'(drop_count), 2);
        chk("wrap_fill", 32'(fill_level), 0);

        // Reset in the middle of a frame.
        pulses0 = drop_pulses;
        send_frame(10, 8'h33, -1, 1'b0);
        chk("pre_rst_fill", 32'(fill_level), 10);
        in_data = 8'hAA; in_valid = 1'b1;
        rst_n = 1'b0;
        @(posedge clk); #1;
        chk("mid_rst_out_valid", 32'(out_valid), 0);
        chk("mid_rst_out_last", 32'(out_last), 0);
        chk("mid_rst_out_data", 32'(out_data), 0);
        chk("mid_rst_frame_drop", 32'(frame_drop), 0);
        chk("mid_rst_drop_count", 32'(drop_count), 0);
        chk("mid_rst_avail", 32'(frames_avail), 0);
        chk("mid_rst_fill", 32'(fill_level), 0);
        in_valid = 1'b0;
        rst_n = 1'b1;
        idle(2);
        send_frame(12, 8'hA0, -1, 1'b1);
        wait_rx(12, 100);
        idle(3);
        cmp_q("post_rst_data");
        chk("post_rst_pulses", 32'(drop_pulses - pulses0), 0);
        chk("post_rst_drop_count", 32'(drop_count), 0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
